// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD text feeder.
package lcd_pkg;

    localparam int unsigned LCD_COLS    = 16;
    localparam int unsigned LCD_CHARS   = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        StScan,
        StWaitRdy,
        StIssue,
        StGap
    } lcd_state_e;

endpackage

// File: rtl/lcd_char_buffer.sv
// 32-entry character shadow with dirty tracking and a registered read at the scan pointer.
module lcd_char_buffer
    import lcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [7:0]           host_data,
    input  logic                 host_clr,
    input  logic                 set_all,
    input  logic                 issue,
    input  logic [ADDR_W-1:0]    ptr,
    output logic [7:0]           rd_data,
    output logic [LCD_CHARS-1:0] dirty
);

    logic [7:0]           ram_q [LCD_CHARS];
    logic [7:0]           ram_d [LCD_CHARS];
    logic [LCD_CHARS-1:0] dirty_q, dirty_d;
    logic [7:0]           rd_q;

    // Issue clears first so that any same-cycle host activity wins and re-dirties the entry.
    always_comb begin
        ram_d   = ram_q;
        dirty_d = dirty_q;
        if (issue) begin
            dirty_d[ptr] = 1'b0;
        end
        if (set_all) begin
            dirty_d = '1;
        end
        if (host_clr) begin
            for (int i = 0; i < LCD_CHARS; i++) begin
                ram_d[i] = ASCII_SPACE;
            end
            dirty_d = '1;
        end
        if (host_we) begin
            ram_d[host_addr]   = host_data;
            dirty_d[host_addr] = 1'b1;
        end
    end

    // Read the next-state RAM so a write landing just before issue is the value sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LCD_CHARS; i++) begin
                ram_q[i] <= ASCII_SPACE;
            end
            dirty_q <= '1;
            rd_q    <= ASCII_SPACE;
        end else begin
            ram_q   <= ram_d;
            dirty_q <= dirty_d;
            rd_q    <= ram_d[ptr];
        end
    end

    assign rd_data = rd_q;
    assign dirty   = dirty_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// Streams dirty characters of a 16x2 shadow buffer to the HD44780 controller, paced by ready
// and a minimum gap. Optional periodic full repaint: define LCD_FULL_REFRESH_EN.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 10000,
    parameter int unsigned REFRESH_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_data,
    input  logic              host_clr,
    input  logic              lcd_ready,
    output logic [7:0]        char_data,
    output logic [ADDR_W-1:0] cursor_pos,
    output logic              write_enable,
    output logic              busy
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    lcd_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic [7:0]           char_q, char_d;
    logic [ADDR_W-1:0]    pos_q, pos_d;
    logic [7:0]           rd_data;
    logic [LCD_CHARS-1:0] dirty;
    logic                 issue;
    logic                 set_all;

    assign issue = (state_q == StIssue);

`ifdef LCD_FULL_REFRESH_EN
    localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [RefW-1:0] ref_q;

    assign set_all = (ref_q == RefW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q <= '0;
        end else if (set_all) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end
`else
    // Refresh disabled; the period parameter stays so both builds share one interface.
    assign set_all = 1'b0 && (REFRESH_CYCLES == 0);
`endif

    lcd_char_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_clr  (host_clr),
        .set_all   (set_all),
        .issue     (issue),
        .ptr       (ptr_q),
        .rd_data   (rd_data),
        .dirty     (dirty)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        char_d  = char_q;
        pos_d   = pos_q;
        unique case (state_q)
            StScan: begin
                if (dirty[ptr_q]) begin
                    state_d = StWaitRdy;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StWaitRdy: begin
                if (lcd_ready) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                char_d  = rd_data;
                pos_d   = ptr_q;
                gap_d   = GapW'(GAP_CYCLES - 1);
                ptr_d   = ptr_q + 1'b1;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StScan;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StScan;
            ptr_q   <= '0;
            gap_q   <= '0;
            char_q  <= 8'h00;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            char_q  <= char_d;
            pos_q   <= pos_d;
        end
    end

    // Outputs show the live entry during issue and hold the last sent pair otherwise.
    assign write_enable = issue;
    assign char_data    = issue ? rd_data : char_q;
    assign cursor_pos   = issue ? ptr_q : pos_q;
    assign busy         = (|dirty) || (state_q == StGap);

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Randomised and directed checks of lcd_text_buffer against a character/dirty-set model.
module tb_lcd_text_buffer;

    localparam int G = 8;
    localparam int R = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_we;
    logic [4:0] host_addr;
    logic [7:0] host_data;
    logic       host_clr;
    logic       lcd_ready;
    logic [7:0] char_data;
    logic [4:0] cursor_pos;
    logic       write_enable;
    logic       busy;

    lcd_text_buffer #(
        .GAP_CYCLES     (G),
        .REFRESH_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_clr     (host_clr),
        .lcd_ready    (lcd_ready),
        .char_data    (char_data),
        .cursor_pos   (cursor_pos),
        .write_enable (write_enable),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     pos;
        int     data;
        longint t;
    } pulse_t;

    pulse_t pq[$];
    int     n_vec = 0;
    int     n_err = 0;

    // Model: what the display should hold, which positions still owe a write, and when.
    int     m_ram   [32];
    bit     m_dirty [32];
    longint m_since [32];
    longint cyc = 0;
    longint last_ref;
    bit     have_pulse;
    int     last_pos;
    int     out_data;
    int     out_pos;
    int     stall;
    longint since_rst;
    bit     prev_ready;

    function automatic void chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    function automatic void mark(int i);
        if (!m_dirty[i]) begin
            m_since[i] = cyc;
        end
        m_dirty[i] = 1'b1;
    endfunction

    function automatic pulse_t pget(int i);
        pulse_t p;
        p = '{pos: -1, data: -1, t: -1};
        if (i < pq.size()) begin
            p = pq[i];
        end
        return p;
    endfunction

    always @(negedge clk) begin
        bit any;
        bit exp_busy;
        int skipped;
        int j;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_ram[i]   = 32'h20;
                m_dirty[i] = 1'b1;
                m_since[i] = cyc;
            end
            last_ref   = cyc;
            have_pulse = 1'b0;
            last_pos   = 31;
            out_data   = 0;
            out_pos    = 0;
            stall      = 0;
            since_rst  = 0;
            prev_ready = 1'b0;
            chk("rst_we", write_enable, 0);
            chk("rst_busy", busy, 1);
            chk("rst_char", char_data, 0);
            chk("rst_pos", cursor_pos, 0);
        end else begin
            any = 1'b0;
            for (int i = 0; i < 32; i++) begin
                any |= m_dirty[i];
            end
            exp_busy = any || (have_pulse && (cyc - last_ref >= 1) && (cyc - last_ref <= G));
            chk("busy", busy, exp_busy);
            if (write_enable) begin
                chk("pulse_ready", prev_ready, 1);
                chk("pulse_dirty", m_dirty[cursor_pos], 1);
                chk("pulse_data", char_data, m_ram[cursor_pos]);
                if (have_pulse) begin
                    chk("pulse_spacing", (cyc - last_ref) >= G + 2, 1);
                end
                skipped = 0;
                j = (last_pos + 1) % 32;
                while (j != int'(cursor_pos)) begin
                    if (m_dirty[j] && m_since[j] <= last_ref) begin
                        skipped++;
                    end
                    j = (j + 1) % 32;
                end
                chk("pulse_order", skipped, 0);
                pq.push_back('{pos: int'(cursor_pos), data: int'(char_data), t: cyc});
                last_ref   = cyc;
                have_pulse = 1'b1;
                last_pos   = int'(cursor_pos);
                out_data   = int'(char_data);
                out_pos    = int'(cursor_pos);
                stall      = 0;
            end else begin
                chk("hold_char", char_data, out_data);
                chk("hold_pos", cursor_pos, out_pos);
                if (any && lcd_ready) begin
                    stall++;
                end
                if (stall > G + 40) begin
                    chk("stall_bound", stall, G + 40);
                    stall = 0;
                end
            end
            // Next-edge update: sent entry is clean unless host activity re-dirties it.
            if (write_enable) begin
                m_dirty[cursor_pos] = 1'b0;
            end
`ifdef LCD_FULL_REFRESH_EN
            if (since_rst % R == R - 1) begin
                for (int i = 0; i < 32; i++) begin
                    mark(i);
                end
            end
`endif
            if (host_clr) begin
                for (int i = 0; i < 32; i++) begin
                    m_ram[i] = 32'h20;
                    mark(i);
                end
            end
            if (host_we) begin
                m_ram[host_addr] = int'(host_data);
                mark(int'(host_addr));
            end
            since_rst++;
            prev_ready = lcd_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, int d);
        host_we   = 1'b1;
        host_addr = 5'(a);
        host_data = 8'(d);
        step();
        host_we = 1'b0;
    endtask

    task automatic wait_pulses(int n, int budget);
        int k = 0;
        while (pq.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("pulse_count", pq.size() >= n, 1);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        chk("drain_busy", busy, 0);
    endtask

    task automatic check_repaint(string tag, int data);
        pulse_t p;
        for (int i = 0; i < 32; i++) begin
            p = pget(i);
            chk({tag, "_pos"}, p.pos, i);
            chk({tag, "_data"}, p.data, data);
        end
    endtask

    initial begin
        pulse_t p0;
        pulse_t p1;
        longint t0;
        rst       = 1'b1;
        host_we   = 1'b0;
        host_addr = '0;
        host_data = '0;
        host_clr  = 1'b0;
        lcd_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Power-up repaint: 32 spaces in position order, then idle.
        wait_pulses(32, 32 * (G + 4) + 100);
        check_repaint("boot", 32'h20);
        wait_idle(G + 10);
        pq.delete();

`ifdef LCD_FULL_REFRESH_EN
        repeat (R + 100) step();
        chk("refresh_repaint", pq.size() >= 32, 1);
        wait_idle(2 * R);
        pq.delete();
`else
        // Two writes stream out in address order.
        wr(5, 8'h41);
        wr(20, 8'h42);
        wait_pulses(2, 200);
        repeat (100) step();
        chk("two_count", pq.size(), 2);
        p0 = pget(0);
        p1 = pget(1);
        chk("two_pos0", p0.pos, 5);
        chk("two_data0", p0.data, 8'h41);
        chk("two_pos1", p1.pos, 20);
        chk("two_data1", p1.data, 8'h42);
        chk("two_gap", (p1.t - p0.t) >= 10, 1);
        wait_idle(G + 10);
        pq.delete();

        // Ready held low blocks the write; raising it issues one cycle later.
        lcd_ready = 1'b0;
        wr(3, 8'h33);
        repeat (50) step();
        chk("ready_low_none", pq.size(), 0);
        lcd_ready = 1'b1;
        t0 = cyc;
        wait_pulses(1, 20);
        p0 = pget(0);
        chk("ready_pos", p0.pos, 3);
        chk("ready_data", p0.data, 8'h33);
        chk("ready_latency", p0.t, t0 + 2);
        wait_idle(G + 10);
        pq.delete();

        // Host write colliding with the issue of the same entry forces a resend.
        lcd_ready = 1'b0;
        wr(7, 8'h37);
        repeat (40) step();
        lcd_ready = 1'b1;
        step();
        wr(7, 8'h5A);
        wait_pulses(2, 200);
        repeat (60) step();
        chk("coll_count", pq.size(), 2);
        p0 = pget(0);
        p1 = pget(1);
        chk("coll_pos0", p0.pos, 7);
        chk("coll_data0", p0.data, 8'h37);
        chk("coll_pos1", p1.pos, 7);
        chk("coll_data1", p1.data, 8'h5A);
        wait_idle(G + 10);
        pq.delete();

        // Fill with '1', drain, then clear: 32 spaces in cyclic order.
        for (int a = 0; a < 32; a++) begin
            wr(a, 8'h31);
        end
        wait_idle(32 * (G + 4) + 100);
        pq.delete();
        host_clr = 1'b1;
        step();
        host_clr = 1'b0;
        wait_pulses(32, 32 * (G + 4) + 100);
        p0 = pget(0);
        for (int i = 0; i < 32; i++) begin
            p1 = pget(i);
            chk("clr_pos", p1.pos, (p0.pos + i) % 32);
            chk("clr_data", p1.data, 8'h20);
        end
        wait_idle(G + 10);
        pq.delete();
`endif

        // Random traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            host_we   = ($urandom_range(0, 9) == 0);
            host_addr = 5'($urandom_range(0, 31));
            host_data = 8'($urandom_range(32, 126));
            host_clr  = ($urandom_range(0, 299) == 0);
            lcd_ready = ($urandom_range(0, 4) != 0);
            step();
        end
        host_we   = 1'b0;
        host_clr  = 1'b0;
        lcd_ready = 1'b1;
        wait_idle(32 * (G + 4) + 2 * R);
        pq.delete();

        // Reset in the middle of a gap restarts the repaint from position 0.
        wr(10, 8'h55);
        wait_pulses(1, 100);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rst_mid_we", write_enable, 0);
        chk("rst_mid_pos", cursor_pos, 0);
        chk("rst_mid_busy", busy, 1);
        step();
        step();
        rst = 1'b0;
        pq.delete();
        wait_pulses(32, 32 * (G + 4) + 100);
        check_repaint("rerst", 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
